rsa_operand_loader: RTL and testbench
=====================================

Name: rsa_operand_loader

Overview:
- Consumer of the 256x32 instruction/operand SRAM.
- After a start pulse it reads the three 2048-bit RSA operands out of that SRAM: modulus N, then exponent key E/D, then message block.
- Each operand is 64 x 32-bit words. The block streams them word by word to the modular-exponentiation core over a valid/ready interface, tagging each word with operand select and word index.
- It hides the SRAM's one-cycle registered-address read latency and absorbs downstream backpressure without losing or duplicating words.

Parameters:
- AW, 8, SRAM address width.
- DW, 32, data word width.
- WORDS, 64, words per operand (2048/32).
- MSG_BASE, 0, SRAM base address of message block.
- KEY_BASE, 64, SRAM base address of E or D key.
- MOD_BASE, 128, SRAM base address of modulus N.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- sram_en  out  1  SRAM read enable; SRAM latches sram_addr on the edge where sram_en=1.
- sram_addr  out  AW  SRAM read address.
- sram_data  in  DW  SRAM read data, valid in the cycle after an enabled edge; holds while sram_en=0.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts; transfer = out_valid & out_ready at rising edge.
- out_data  out  DW  operand word.
- out_sel  out  2  0=MOD, 1=KEY, 2=MSG (3 never driven).
- out_idx  out  6  word index within operand, 0 = least-significant word.
- out_last  out  1  high when out_idx == WORDS-1.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, stream complete.

Behaviour:
- Reset values: sram_en=0, sram_addr=0, out_valid=0, out_data=0, out_sel=0, out_idx=0, out_last=0, busy=0, done=0. FIFO empty, in-flight flag clear, state IDLE.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE -> FETCH on start=1.
  - FETCH -> DRAIN on the cycle the 192nd read is issued.
  - DRAIN -> DONE on the edge completing the 192nd output transfer.
  - DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
- start outside IDLE is ignored. There is no queued restart.
- Read sequence: addresses MOD_BASE..MOD_BASE+63, then KEY_BASE..+63, then MSG_BASE..+63. An issue counter (0..191) drives sram_addr and the sel/idx tag pipeline.
- Issue rule: in FETCH, sram_en=1 iff (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready. sram_en is combinational from registered state; sram_addr = current issue address.
- Capture: inflight is set on an issuing edge. On the next edge, sram_data together with the delayed sel/idx tag is written into a 2-entry FIFO. sram_data is sampled only in that capture cycle.
- Output: out_* come from the FIFO head; out_valid = FIFO non-empty.
  - Simultaneous push and pop in the same edge is legal at any occupancy; count unchanged.
  - Order strictly preserved.
  - out_data/out_sel/out_idx hold stable while out_valid=1 and out_ready=0.
- Latency: start sampled at edge E0.
  - First sram_en in the cycle after E0.
  - First out_valid after E2 (data ram[MOD_BASE]).
  - With out_ready held 1: 192 transfers on 192 consecutive edges.
  - done high the cycle after the final transfer.
- Backpressure: FIFO never exceeds 2 entries. Reads stall while count+inflight=2 and resume the cycle after a pop.
- Index wrap: out_idx wraps 63 -> 0 as out_sel advances MOD -> KEY -> MSG; out_last=1 exactly on idx 63 of each operand.
- Reset mid-operation (any state): all of the following take their reset values immediately:
  - FIFO flushed.
  - In-flight read discarded.
  - Counters cleared.
  - sram_en=0.
- After reset release, nothing happens until a new start.

Test Plan:
- Reset then idle 10 cycles, start never asserted -> sram_en=0, out_valid=0, busy=0, done=0 throughout.
- SRAM word = address (ram[a]=a), out_ready=1, start pulse at E0 -> first out_valid after E2 with data=128, sel=0, idx=0. Then 191 back-to-back words: 129..191, 64..127, 0..63. out_last on data 191, 127, 63. done one cycle after the last transfer, busy low next cycle.
- out_ready=0 for 10 cycles starting at word 5 -> at most 2 words buffered, sram_en low once full, out_data=133 held stable. On ready=1 the stream continues 133,134,... with no gaps or duplicates; 192 total.
- Random out_ready (50%) over whole stream -> sequence matches the expected 192-word order exactly, one done pulse, tag/data always consistent.
- start re-pulsed mid-stream (during FETCH and DRAIN) -> ignored, single 192-word stream, single done.
- rst asserted mid-KEY operand with FIFO full -> same cycle: out_valid=0, sram_en=0, busy=0. New start afterwards restarts at address 128, idx 0.

Source files
------------

// File: rtl/rsa_operand_loader.sv
// Streams the three 2048-bit RSA operands (modulus, key, message) out of the
// operand SRAM as tagged 32-bit words over a valid/ready interface.
module rsa_operand_loader #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int WORDS    = 64,
    parameter int MSG_BASE = 0,
    parameter int KEY_BASE = 64,
    parameter int MOD_BASE = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          sram_en,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_sel,
    output logic [5:0]    out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    localparam int TOTAL = 3 * WORDS;
    localparam int CW    = $clog2(TOTAL);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
    logic            inflight_q, inflight_d;
    logic [7:0]      tag_q, tag_d;
    logic [DW-1:0]   fifo_data_q [2];
    logic [DW-1:0]   fifo_data_d [2];
    logic [7:0]      fifo_tag_q [2];
    logic [7:0]      fifo_tag_d [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;

    logic            pop;
    logic [2:0]      occ;
    logic [1:0]      issue_sel;
    logic [5:0]      issue_idx;
    logic [AW-1:0]   issue_addr;

    // Operand order is MOD, KEY, MSG, so the issue counter's quotient is the sel tag.
    always_comb begin
        issue_sel = 2'(issue_cnt_q / CW'(WORDS));
        issue_idx = 6'(issue_cnt_q % CW'(WORDS));
        case (issue_sel)
            2'd0:    issue_addr = AW'(MOD_BASE) + AW'(issue_idx);
            2'd1:    issue_addr = AW'(KEY_BASE) + AW'(issue_idx);
            default: issue_addr = AW'(MSG_BASE) + AW'(issue_idx);
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        out_valid = (count_q != 2'd0);
        out_data  = fifo_data_q[rd_ptr_q];
        out_sel   = fifo_tag_q[rd_ptr_q][7:6];
        out_idx   = fifo_tag_q[rd_ptr_q][5:0];
        out_last  = (out_idx == 6'(WORDS - 1));
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);

        pop       = out_valid && out_ready;
        // Slots already promised: buffered words plus the read in flight, less the word leaving.
        occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        sram_en   = (state_q == FETCH) && (occ < 3'd2);
        sram_addr = (state_q == FETCH) ? issue_addr : '0;

        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        inflight_d  = sram_en;
        tag_d       = tag_q;
        fifo_data_d = fifo_data_q;
        fifo_tag_d  = fifo_tag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + 2'(inflight_q) - 2'(pop);

        if (sram_en) begin
            tag_d       = {issue_sel, issue_idx};
            issue_cnt_d = issue_cnt_q + 1'b1;
        end

        // Read data is valid exactly one cycle after the enabled edge.
        if (inflight_q) begin
            fifo_data_d[wr_ptr_q] = sram_data;
            fifo_tag_d[wr_ptr_q]  = tag_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH;
                    issue_cnt_d = '0;
                end
            end
            FETCH: begin
                if (sram_en && issue_cnt_q == CW'(TOTAL - 1)) begin
                    state_d     = DRAIN;
                    issue_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (pop && out_sel == 2'd2 && out_last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
            // NOTE: the two FIFO slots are reset too, so out_data reads 0 out of reset.
            fifo_data_q <= '{default: '0};
            fifo_tag_q  <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            fifo_data_q <= fifo_data_d;
            fifo_tag_q  <= fifo_tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_rsa_operand_loader.sv
// Randomised bench for rsa_operand_loader: SRAM model, expected-word list built
// from the operand layout, and per-transfer comparison of data and tags.
module tb_rsa_operand_loader;
    logic        clk = 1'b0;
    logic        rst, start, sram_en, out_ready, out_valid, out_last, busy, done;
    logic [7:0]  sram_addr;
    logic [31:0] sram_data, out_data;
    logic [1:0]  out_sel;
    logic [5:0]  out_idx;

    logic [31:0] ram [256];
    logic [7:0]  rd_addr;
    int          n_cmp = 0;
    int          n_err = 0;

    rsa_operand_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .sram_en(sram_en), .sram_addr(sram_addr), .sram_data(sram_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sram_en) rd_addr <= sram_addr;
    assign sram_data = ram[rd_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_ram(input bit rnd);
        for (int a = 0; a < 256; a++) ram[a] = rnd ? $urandom : 32'(a);
    endtask

    // mode 0: ready=1, 1: 10-cycle stall at word 5, 2: random ready,
    // 3: random ready + ignored start pulses, 4: reset mid-KEY with FIFO full
    task automatic run_stream(input int mode);
        logic [40:0] expq[$];
        int bases[3] = '{128, 64, 0};
        int n = 0, issued = 0, dones = 0, cyc = 0, stall = 0;
        int first_valid = -1, last_x = -1, done_cyc = -1, max_out = 0;

        for (int op = 0; op < 3; op++)
            for (int i = 0; i < 64; i++)
                expq.push_back({i == 63, 2'(op), 6'(i), ram[bases[op] + i]});

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        while (cyc < 3000) begin
            @(negedge clk);
            case (mode)
                0: out_ready = 1'b1;
                1: if (n == 5 && stall < 10) begin out_ready = 1'b0; stall++; end
                   else out_ready = 1'b1;
                4: begin out_ready = (n < 70); if (n >= 70) stall++; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 3) start = (cyc == 40) || (issued == 192 && n < 192);
            #1;
            if (mode == 4 && stall == 4) begin
                rst = 1'b1;
                #1;
                check("rst_mid", {out_valid, sram_en, busy, done, out_data},
                      64'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (issued - n > max_out) max_out = issued - n;
            if (mode == 0 && cyc == 0)
                check("first_issue", {sram_en, sram_addr}, {1'b1, 8'd128});
            if (mode == 1 && stall == 10 && !out_ready)
                check("stall_hold", {out_valid, sram_en, out_data}, {1'b1, 1'b0, 32'd133});
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                if (n < 192) check($sformatf("word%0d", n), {out_last, out_sel, out_idx, out_data}, expq[n]);
                else         check("extra_word", 1, 0);
                n++;
                last_x = cyc;
            end
            if (sram_en) issued++;
            if (done) begin dones++; done_cyc = cyc; end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("busy_after_done", {busy, done}, 0);
                break;
            end
            cyc++;
        end
        start = 1'b0;

        check("word_count", n, 192);
        check("done_count", dones, 1);
        check("done_latency", done_cyc, last_x + 1);
        check("max_buffered", max_out <= 2, 1);
        if (mode == 0) begin
            check("first_valid", first_valid, 2);
            check("back_to_back", last_x - first_valid, 191);
        end
        if (mode == 3) begin
            int act = 0;
            repeat (10) begin
                @(negedge clk);
                #1 if (sram_en || busy || out_valid) act++;
            end
            check("no_restart", act, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        fill_ram(1'b0);
        repeat (2) @(negedge clk);
        check("reset_vals", {sram_en, sram_addr, out_valid, out_data, out_sel, out_idx,
                             out_last, busy, done}, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 check($sformatf("idle%0d", i), {sram_en, out_valid, busy, done}, 0);
        end

        run_stream(0);
        run_stream(1);
        fill_ram(1'b1);
        run_stream(2);
        run_stream(3);
        fill_ram(1'b0);
        run_stream(4);
        run_stream(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
